// File: rtl/reg_access_arbiter_pkg.sv
// rtl/reg_access_arbiter_pkg.sv - shared types and constants for the register access arbiter
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int MAX_REQ       = 4;
  localparam int IDX_W         = 2;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// rtl/reg_access_arbiter_if.sv - single-cycle register-bank access port
interface reg_access_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
);

  logic                 acc_en;
  logic                 wr_en;
  logic [ADDR_SIZE-1:0] addr;
  logic [7:0]           wdata;
  logic [7:0]           rdata;

  modport master (output acc_en, output wr_en, output addr, output wdata, input rdata);
  modport slave  (input acc_en, input wr_en, input addr, input wdata, output rdata);

endinterface

// File: rtl/reg_access_arbiter_rr_pick.sv
// rtl/reg_access_arbiter_rr_pick.sv - combinational round-robin picker
// Search starts one past ptr_i and wraps modulo N; the first set request wins.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [MAX_REQ-1:0] req_pad;
  logic [IDX_W-1:0]   cand;

  assign req_pad = MAX_REQ'(req_i);

  // Scan from the farthest candidate down so the nearest one overwrites last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (req_pad[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin arbiter for the shared register-bank access port
// Define ARB_LOCK_EN to let a requester keep the bank across accesses via lock_i.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NUM_REQ   = 2
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0]           wr_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] addr_i,
  input  logic [NUM_REQ*8-1:0]         wdata_i,
  input  logic [NUM_REQ-1:0]           lock_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [7:0]                   rdata_o,
  reg_access_arbiter_if.master         bank
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic                 acc_en_q, acc_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [MAX_REQ-1:0]   req_pad;
  logic [IDX_W-1:0]     pick_idx, win_idx;
  logic                 pick_valid, win_valid;
  logic                 locked, hold;
  logic                 win_wr;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [7:0]           win_wdata;

  assign req_pad = MAX_REQ'(req_i);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef ARB_LOCK_EN
  logic               lock_q;
  logic [MAX_REQ-1:0] lock_pad;

  assign lock_pad = MAX_REQ'(lock_i);
  assign locked   = lock_q;

  // Lock follows the owner's lock_i at DONE and drops once the owner stops requesting.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_IDLE && !req_pad[sel_q]) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      lock_q <= lock_pad[sel_q];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign locked      = 1'b0;
`endif

  assign hold      = locked & req_pad[sel_q];
  assign win_idx   = hold ? sel_q : pick_idx;
  assign win_valid = hold | pick_valid;

  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_wr    = wr_i[k];
        win_addr  = addr_i[k*ADDR_SIZE +: ADDR_SIZE];
        win_wdata = wdata_i[8*k +: 8];
      end
    end
  end

  // Bank-side signals default to 0 so they are only non-zero for the ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    acc_en_d = 1'b0;
    wr_en_d  = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    gnt_d    = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_ACCESS;
          sel_d    = win_idx;
          acc_en_d = 1'b1;
          wr_en_d  = win_wr;
          addr_d   = win_addr;
          wdata_d  = win_wdata;
          gnt_d    = NUM_REQ'(1) << win_idx;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        done_d  = gnt_q;
        rdata_d = wr_en_q ? 8'h00 : bank.rdata;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = sel_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      sel_q    <= '0;
      acc_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      acc_en_q <= acc_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign bank.acc_en = acc_en_q;
  assign bank.wr_en  = wr_en_q;
  assign bank.addr   = addr_q;
  assign bank.wdata  = wdata_q;
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single register-bank access port (acc_en/wr_en/addr/wdata/rdata) of the filter register block between NUM_REQ requesters, e.g. host serial interface and on-chip interrupt service/config sequencer.
- Round-robin arbitration, one fully registered single-cycle bank access per grant, read data returned with a done pulse.
- Guarantees exactly one acc_en cycle per access, because INT_STATUS reads clear on access.

Parameters:
- ADDR_SIZE, 8, register address width; matches bank addr width.
- NUM_REQ, 2, number of requesters; legal range 2..4.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  reset; asynchronous, active-low.
- req_i  input  NUM_REQ  per-requester access request, level.
- wr_i  input  NUM_REQ  per-requester 1=write, 0=read (read of status regs = clear).
- addr_i  input  NUM_REQ*ADDR_SIZE  per-requester address, slice k at [k*ADDR_SIZE +: ADDR_SIZE].
- wdata_i  input  NUM_REQ*8  per-requester write data, slice k at [8*k +: 8].
- lock_i  input  NUM_REQ  per-requester bus lock; used only with ARB_LOCK_EN.
- gnt_o  output  NUM_REQ  one-hot pulse: the bank access for requester k is being performed this cycle.
- done_o  output  NUM_REQ  one-hot pulse: access complete, rdata_o valid.
- rdata_o  output  8  read data of the last completed access.
- acc_en_o  output  1  bank access enable.
- wr_en_o  output  1  bank write enable.
- addr_o  output  ADDR_SIZE  bank address.
- wdata_o  output  8  bank write data.
- rdata_i  input  8  bank read data; combinational from the bank while acc_en_o=1 and wr_en_o=0.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM:
  - IDLE: if any req_i is set, select a winner and register its wr/addr/wdata plus the select index; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle. acc_en_o=1, gnt_o[sel]=1, wr_en_o/addr_o/wdata_o driven from the registered copy. At the closing edge, rdata_o <= rdata_i for a read, or 0 for a write. Go to DONE.
  - DONE: one cycle. done_o[sel]=1; update RR pointer to sel. Go to IDLE.
- Latency: req sampled at edge t → gnt_o/acc_en_o high in cycle t+1 → done_o in cycle t+2. Throughput: one access per 3 cycles.
- Outside ACCESS, acc_en_o, wr_en_o, addr_o and wdata_o are all 0. They are registered outputs with no combinational path from req_i.
- Round-robin: search starts at pointer+1 and wraps modulo NUM_REQ; the first set req_i wins.
- Requester rules:
  - Hold req/wr/addr/wdata until done_o.
  - Deassert req_i in the DONE cycle, or a new access is started.
  - Inputs changed after IDLE sampling have no effect on the current access.
  - req_i dropped before it is sampled: no access.
- rdata_o holds its value until the next completed access.
- Reset mid-access: immediately return to IDLE with all outputs 0. No partial access and no done_o. The bank is reset by the same rstn_i.
- An address out of bank range is forwarded unchanged; the bank returns 0.

Optional Feature:
- ARB_LOCK_EN defined:
  - If lock_i[sel] is high in the DONE cycle, the arbiter enters locked mode. IDLE then considers only req_i[sel], and other requesters wait.
  - The lock is released when lock_i[sel] is low in a DONE cycle, or when IDLE sees req_i[sel]=0.
  - Intended for atomic read-modify-write of FILTER_CTRL.
- ARB_LOCK_EN undefined: lock_i is ignored (port kept); pure round-robin.

Decomposition:
- Package reg_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - default ADDR_SIZE;
  - MAX_REQ=4;
  - index width constant (2 bits).
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector, pointer. Outputs: winner index, valid.

Test Plan:
- Single read: req_i=01, wr_i=0, addr slice0=0x03, rdata_i=0x5A during ACCESS → acc_en_o high exactly one cycle at t+1 with addr_o=0x03, done_o=01 at t+2, rdata_o=0x5A.
- Single write: req1 write addr=0x01, wdata=0xC7 → at t+1 wr_en_o=1, addr_o=0x01, wdata_o=0xC7, gnt_o=10; done_o=10 at t+2; rdata_o=0.
- Contention: both req held for 4 accesses from reset → grant order 0,1,0,1; never two gnt bits set; no acc_en_o gaps shorter than 2 idle cycles.
- Destructive read: requester 0 reads status addr N with the bank attached and int bit 2 set → exactly one acc_en cycle; rdata_o=0x04; a second read returns 0x00.
- Reset mid-op: assert rstn_i low during ACCESS → all outputs 0 asynchronously; after release, requester 0 wins first even if requester 1 last held the bus.
- ARB_LOCK_EN: req0 with lock high does read then write addr 0x02 while req1 is pending → both req0 accesses complete before gnt_o[1]; without the macro, grant order is 0,1,0.
